// File: rtl/mmp_pkg.sv
// Shared definitions for the MMP command FIFO drain: op codes, word field
// positions, FSM state encoding and default bus timing.
package mmp_pkg;

  localparam logic [1:0] OP_OPLL  = 2'b00;
  localparam logic [1:0] OP_PSG   = 2'b01;
  localparam logic [1:0] OP_SCC   = 2'b10;
  localparam logic [1:0] OP_DELAY = 2'b11;

  // 24-bit command word layout; [21:16] carries nothing we use
  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 22;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;

  localparam int unsigned WR_PULSE_DEF   = 4;
  localparam int unsigned ADDR_WAIT_DEF  = 12;
  localparam int unsigned DATA_WAIT_DEF  = 84;
  localparam int unsigned DELAY_UNIT_DEF = 27;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_A_WR   = 3'd3,
    ST_A_WAIT = 3'd4,
    ST_D_WR   = 3'd5,
    ST_D_WAIT = 3'd6,
    ST_DLY    = 3'd7
  } state_e;

  // Chip select for a write op; the delay op selects no chip
  function automatic logic [2:0] cs_onehot(input logic [1:0] op);
    logic [2:0] cs;
    case (op)
      OP_OPLL: cs = 3'b001;
      OP_PSG:  cs = 3'b010;
      OP_SCC:  cs = 3'b100;
      default: cs = 3'b000;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/mmp_tick_timer.sv
// Prescaled down-counter. Loading sets the tick count and the prescale;
// o_last is high during the final cycle of count*prescale cycles that
// follow the load edge, so the owner leaves its state on that cycle.
module mmp_tick_timer (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_load,
  input  logic [15:0] i_count,
  input  logic [15:0] i_prescale,
  output logic        o_last
);

  logic [15:0] presc_q, presc_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d;

  // Reload on request, otherwise count prescale cycles per tick down to zero
  always_comb begin
    presc_d = presc_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      presc_d = i_prescale;
      pre_d   = i_prescale - 16'd1;
      cnt_d   = i_count;
    end else if (cnt_q != 16'd0) begin
      if (pre_q == 16'd0) begin
        cnt_d = cnt_q - 16'd1;
        pre_d = presc_q - 16'd1;
      end else begin
        pre_d = pre_q - 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      presc_q <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_last = (cnt_q == 16'd1) && (pre_q == 16'd0);

endmodule

// File: rtl/mmp_fifo_drain.sv
// Pop side of the MMP command FIFO: fetches one word at a time and turns it
// into a paced two-phase chip write (address, then data) or a timed delay.
//
// state   | meaning
// IDLE    | waiting for enable and a non-empty FIFO
// POP     | one-cycle pop strobe
// LOAD    | capture FIFO read data, decode op
// A_WR    | address phase, o_WR high
// A_WAIT  | address recovery, o_WR low
// D_WR    | data phase, o_WR high
// D_WAIT  | data recovery, o_WR low
// DLY     | count*DELAY_UNIT idle cycles
module mmp_fifo_drain
  import mmp_pkg::*;
#(
  parameter int unsigned WR_PULSE   = WR_PULSE_DEF,
  parameter int unsigned ADDR_WAIT  = ADDR_WAIT_DEF,
  parameter int unsigned DATA_WAIT  = DATA_WAIT_DEF,
  parameter int unsigned DELAY_UNIT = DELAY_UNIT_DEF
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_ENABLE,
  input  logic        i_EMPTY,
  output logic        o_POP_S,
  input  logic [23:0] i_POP_DT,
  output logic [2:0]  o_CS,
  output logic        o_A0,
  output logic        o_WR,
  output logic [7:0]  o_DO,
  output logic        o_BUSY
);

  localparam logic [15:0] WR_PULSE_C   = 16'(WR_PULSE);
  localparam logic [15:0] ADDR_WAIT_C  = 16'(ADDR_WAIT);
  localparam logic [15:0] DATA_WAIT_C  = 16'(DATA_WAIT);
  localparam logic [15:0] DELAY_UNIT_C = 16'(DELAY_UNIT);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] body_q, body_d;
  logic        pop_q, pop_d;
  logic [2:0]  cs_q, cs_d;
  logic        a0_q, a0_d;
  logic        wr_q, wr_d;
  logic [7:0]  dout_q, dout_d;
  logic        busy_q, busy_d;

  logic        tmr_load;
  logic [15:0] tmr_count;
  logic [15:0] tmr_prescale;
  logic        tmr_last;

  logic        unused_pop_bits;
  assign unused_pop_bits = ^i_POP_DT[21:16];

  mmp_tick_timer u_timer (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_load     (tmr_load),
    .i_count    (tmr_count),
    .i_prescale (tmr_prescale),
    .o_last     (tmr_last)
  );

  // Next state, next registered outputs and timer loads, decided together so
  // every output changes on the same edge as the state it belongs to
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    body_d       = body_q;
    pop_d        = 1'b0;
    cs_d         = cs_q;
    a0_d         = a0_q;
    wr_d         = wr_q;
    dout_d       = dout_q;
    tmr_load     = 1'b0;
    tmr_count    = 16'd0;
    tmr_prescale = 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (i_ENABLE && !i_EMPTY) begin
          state_d = ST_POP;
          pop_d   = 1'b1;
        end
      end
      ST_POP: state_d = ST_LOAD;
      ST_LOAD: begin
        op_d   = i_POP_DT[OP_MSB:OP_LSB];
        body_d = i_POP_DT[CNT_MSB:CNT_LSB];
        if (op_d == OP_DELAY) begin
          if (body_d == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_DLY;
            tmr_load     = 1'b1;
            tmr_count    = body_d;
            tmr_prescale = DELAY_UNIT_C;
          end
        end else begin
          state_d   = ST_A_WR;
          cs_d      = cs_onehot(op_d);
          a0_d      = 1'b0;
          dout_d    = i_POP_DT[REG_MSB:REG_LSB];
          wr_d      = 1'b1;
          tmr_load  = 1'b1;
          tmr_count = WR_PULSE_C;
        end
      end
      ST_A_WR: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          if (ADDR_WAIT_C != 16'd0) begin
            state_d   = ST_A_WAIT;
            wr_d      = 1'b0;
            tmr_count = ADDR_WAIT_C;
          end else begin
            // zero recovery: address pulse runs straight into data pulse
            state_d   = ST_D_WR;
            a0_d      = 1'b1;
            dout_d    = body_q[DAT_MSB:DAT_LSB];
            tmr_count = WR_PULSE_C;
          end
        end
      end
      ST_A_WAIT: begin
        if (tmr_last) begin
          state_d   = ST_D_WR;
          a0_d      = 1'b1;
          dout_d    = body_q[DAT_MSB:DAT_LSB];
          wr_d      = 1'b1;
          tmr_load  = 1'b1;
          tmr_count = WR_PULSE_C;
        end
      end
      ST_D_WR: begin
        if (tmr_last) begin
          wr_d = 1'b0;
          if (DATA_WAIT_C != 16'd0) begin
            state_d   = ST_D_WAIT;
            tmr_load  = 1'b1;
            tmr_count = DATA_WAIT_C;
          end else begin
            state_d = ST_IDLE;
            cs_d    = 3'b000;
          end
        end
      end
      ST_D_WAIT: begin
        if (tmr_last) begin
          state_d = ST_IDLE;
          cs_d    = 3'b000;
        end
      end
      ST_DLY: begin
        if (tmr_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, captured word and registered bus outputs
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      body_q  <= '0;
      pop_q   <= 1'b0;
      cs_q    <= '0;
      a0_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      body_q  <= body_d;
      pop_q   <= pop_d;
      cs_q    <= cs_d;
      a0_q    <= a0_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign o_POP_S = pop_q;
  assign o_CS    = cs_q;
  assign o_A0    = a0_q;
  assign o_WR    = wr_q;
  assign o_DO    = dout_q;
  assign o_BUSY  = busy_q;

endmodule

// File: tb/tb_mmp_fifo_drain.sv
// Directed bench for mmp_fifo_drain with default timing and a small FIFO model.
module tb_mmp_fifo_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        empty;
  logic        pop_s;
  logic [23:0] pop_dt = '0;
  logic [2:0]  cs;
  logic        a0;
  logic        wr;
  logic [7:0]  dout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: bench pushes, DUT pops
  logic [23:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  int cyc = 0;
  int n_pops = 0;
  int n_double = 0;
  int pop_cyc [0:15];
  logic pop_prev = 1'b0;

  always #5 clk = ~clk;

  mmp_fifo_drain dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_ENABLE (enable),
    .i_EMPTY  (empty),
    .o_POP_S  (pop_s),
    .i_POP_DT (pop_dt),
    .o_CS     (cs),
    .o_A0     (a0),
    .o_WR     (wr),
    .o_DO     (dout),
    .o_BUSY   (busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_s && !empty) begin
      pop_dt <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    pop_prev <= pop_s;
    if (pop_s) begin
      pop_cyc[n_pops[3:0]] <= cyc;
      n_pops <= n_pops + 1;
      if (pop_prev) n_double <= n_double + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig_of(input int sel);
    return (sel == 0) ? wr : busy;
  endfunction

  // Length of the run of sel==val starting at the current sample
  task automatic run_len(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig_of(sel) == val && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_pop(input string tag, input int limit);
    int n = 0;
    while (!pop_s && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, 32'(pop_s), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;

    // reset values
    step(3);
    chk_eq("rst_pop", 32'(pop_s), 32'd0);
    chk_eq("rst_cs", 32'(cs), 32'd0);
    chk_eq("rst_a0", 32'(a0), 32'd0);
    chk_eq("rst_wr", 32'(wr), 32'd0);
    chk_eq("rst_do", 32'(dout), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    step(2);
    chk_eq("idle_empty_nopop", 32'(n_pops), 32'd0);

    // OPLL write, then delay 3, then PSG write
    push(24'h001025);
    push(24'hC00003);
    push(24'h400738);
    wait_pop("opll_pop", 5);
    step(1);
    chk_eq("opll_load_busy", 32'(busy), 32'd1);
    chk_eq("opll_load_wr", 32'(wr), 32'd0);
    step(1);
    chk_eq("opll_a_cs", 32'(cs), 32'b001);
    chk_eq("opll_a_a0", 32'(a0), 32'd0);
    chk_eq("opll_a_do", 32'(dout), 32'h10);
    run_len(0, 1'b1, 20, n);
    chk_eq("opll_a_wr_len", 32'(n), 32'd4);
    chk_eq("opll_await_cs", 32'(cs), 32'b001);
    chk_eq("opll_await_do", 32'(dout), 32'h10);
    run_len(0, 1'b0, 40, n);
    chk_eq("opll_a_gap", 32'(n), 32'd12);
    chk_eq("opll_d_a0", 32'(a0), 32'd1);
    chk_eq("opll_d_do", 32'(dout), 32'h25);
    chk_eq("opll_d_cs", 32'(cs), 32'b001);
    run_len(0, 1'b1, 20, n);
    chk_eq("opll_d_wr_len", 32'(n), 32'd4);
    run_len(1, 1'b1, 200, n);
    chk_eq("opll_d_wait", 32'(n), 32'd84);
    chk_eq("opll_idle_cs", 32'(cs), 32'd0);
    chk_eq("opll_idle_a0", 32'(a0), 32'd1);
    chk_eq("opll_idle_do", 32'(dout), 32'h25);

    wait_pop("dly_pop", 5);
    step(3);
    chk_eq("dly_busy", 32'(busy), 32'd1);
    chk_eq("dly_cs", 32'(cs), 32'd0);
    chk_eq("dly_wr", 32'(wr), 32'd0);
    wait_pop("psg_pop", 200);
    step(2);
    chk_eq("psg_cs", 32'(cs), 32'b010);
    chk_eq("psg_do", 32'(dout), 32'h07);
    chk_eq("psg_wr", 32'(wr), 32'd1);
    wait_idle("psg_done", 300);
    chk_eq("space_write", 32'(pop_cyc[1] - pop_cyc[0]), 32'd107);
    chk_eq("space_delay3", 32'(pop_cyc[2] - pop_cyc[1]), 32'd84);

    // zero delay followed by SCC write
    push(24'hC00000);
    push(24'h808AFF);
    wait_pop("dly0_pop", 5);
    step(1);
    wait_pop("scc_pop", 10);
    step(2);
    chk_eq("scc_cs", 32'(cs), 32'b100);
    chk_eq("scc_a_do", 32'(dout), 32'h8A);
    run_len(0, 1'b1, 20, n);
    chk_eq("scc_a_wr_len", 32'(n), 32'd4);
    run_len(0, 1'b0, 40, n);
    chk_eq("scc_a_gap", 32'(n), 32'd12);
    chk_eq("scc_d_do", 32'(dout), 32'hFF);
    chk_eq("scc_d_a0", 32'(a0), 32'd1);
    wait_idle("scc_done", 300);
    chk_eq("space_delay0", 32'(pop_cyc[4] - pop_cyc[3]), 32'd3);

    // disabled: nothing is popped
    enable = 1'b0;
    push(24'h001234);
    push(24'h005678);
    push(24'h009ABC);
    step(30);
    chk_eq("dis_no_pop", 32'(n_pops), 32'd5);
    chk_eq("dis_busy", 32'(busy), 32'd0);

    // enable, then drop it during the data phase of the first word
    enable = 1'b1;
    wait_pop("en_pop", 5);
    step(2);
    chk_eq("en_a_do", 32'(dout), 32'h12);
    run_len(0, 1'b1, 20, n);
    run_len(0, 1'b0, 40, n);
    enable = 1'b0;
    chk_eq("en_d_wr", 32'(wr), 32'd1);
    chk_eq("en_d_do", 32'(dout), 32'h34);
    wait_idle("en_done", 200);
    chk_eq("en_done_do", 32'(dout), 32'h34);
    step(50);
    chk_eq("dis_hold", 32'(n_pops), 32'd6);
    enable = 1'b1;
    wait_pop("reen_pop", 5);

    // reset in the middle of the address recovery
    step(2);
    chk_eq("pre_rst_do", 32'(dout), 32'h56);
    run_len(0, 1'b1, 20, n);
    step(3);
    chk_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_eq("mid_rst_wr", 32'(wr), 32'd0);
    chk_eq("mid_rst_cs", 32'(cs), 32'd0);
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_pop", 32'(pop_s), 32'd0);
    step(1);
    chk_eq("post_rst_pop", 32'(pop_s), 32'd1);
    step(2);
    chk_eq("post_rst_cs", 32'(cs), 32'b001);
    chk_eq("post_rst_do", 32'(dout), 32'h9A);
    wait_idle("post_rst_done", 200);
    step(2);
    chk_eq("total_pops", 32'(n_pops), 32'd8);
    chk_eq("no_double_pop", 32'(n_double), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
